// File: rtl/syr2k_loop_sequencer.sv
// syr2k_loop_sequencer: walks the SYR2K i/j/k loop nest and issues one
// operand-address beat per k step, tracking outstanding C write-backs.
module syr2k_loop_sequencer #(
   parameter int N_MAX   = 100,
   parameter int AW      = 14,
   parameter int DW      = 7,
   parameter bit LOWER   = 1'b1,
   parameter int MAX_OUT = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [DW-1:0] n_cfg,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic          iss_valid,
   input  logic          iss_ready,
   output logic [AW-1:0] addr_ik,
   output logic [AW-1:0] addr_jk,
   output logic [AW-1:0] addr_ij,
   output logic          iss_first,
   output logic          iss_last,
   input  logic          wb_ack
);

   localparam int OW = $clog2(MAX_OUT + 1);
   localparam logic [AW-1:0] STRIDE = AW'(N_MAX);
   localparam logic [DW-1:0] NLIM = DW'(N_MAX);
   localparam logic [OW-1:0] OMAX = OW'(MAX_OUT);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t        state, state_d;
   logic [DW-1:0] n, i, j, k;
   logic [DW-1:0] nm1, jmax;
   logic [AW-1:0] base_i, base_j, row_i, row_j;
   logic [OW-1:0] outst;
   logic          beat;
   logic          accept, run_ok, bad_n;
   logic          xfer, stall, k_end, j_end, i_end, fin;
   logic          inc, dec, spur, drain_done;

   always_comb begin
      nm1        = n - DW'(1);
      jmax       = LOWER ? i : nm1;
      k_end      = (k == nm1);
      j_end      = (j == jmax);
      i_end      = (i == nm1);
      stall      = iss_last && (outst == OMAX);
      iss_valid  = beat && !stall;
      xfer       = iss_valid && iss_ready;
      fin        = xfer && k_end && j_end && i_end;
      accept     = (state == IDLE) && start && !done;
      bad_n      = (n_cfg > NLIM);
      run_ok     = (n_cfg != '0) && !bad_n;
      inc        = xfer && iss_last;
      spur       = wb_ack && (outst == '0) && !inc;
      dec        = wb_ack && !spur;
      row_i      = base_i + STRIDE;
      row_j      = base_j + STRIDE;
      drain_done = (state == DRAIN) && (outst == '0);
      state_d    = state;
      unique case (state)
         IDLE:    if (accept && run_ok) state_d = RUN;
         RUN:     if (fin) state_d = DRAIN;
         DRAIN:   if (drain_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         n         <= '0;
         i         <= '0;
         j         <= '0;
         k         <= '0;
         base_i    <= '0;
         base_j    <= '0;
         addr_ik   <= '0;
         addr_jk   <= '0;
         addr_ij   <= '0;
         iss_first <= 1'b0;
         iss_last  <= 1'b0;
         beat      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         outst     <= '0;
      end else begin
         state <= state_d;
         done  <= 1'b0;
         if (inc && !dec) outst <= outst + OW'(1);
         else if (dec && !inc) outst <= outst - OW'(1);
         if (accept) begin
            n         <= n_cfg;
            i         <= '0;
            j         <= '0;
            k         <= '0;
            base_i    <= '0;
            base_j    <= '0;
            addr_ik   <= '0;
            addr_jk   <= '0;
            addr_ij   <= '0;
            iss_first <= run_ok;
            iss_last  <= run_ok && (n_cfg == DW'(1));
            beat      <= run_ok;
            busy      <= run_ok;
            done      <= !run_ok;
            err       <= bad_n;
         end
         if (xfer) begin
            if (!k_end) begin
               k         <= k + DW'(1);
               addr_ik   <= addr_ik + AW'(1);
               addr_jk   <= addr_jk + AW'(1);
               iss_first <= 1'b0;
               iss_last  <= ((k + DW'(1)) == nm1);
            end else begin
               k         <= '0;
               iss_first <= 1'b1;
               iss_last  <= (n == DW'(1));
               if (!j_end) begin
                  j       <= j + DW'(1);
                  base_j  <= row_j;
                  addr_jk <= row_j;
                  addr_ik <= base_i;
                  addr_ij <= addr_ij + AW'(1);
               end else begin
                  // next row of i; j restarts at row 0
                  j       <= '0;
                  base_j  <= '0;
                  addr_jk <= '0;
                  i       <= i + DW'(1);
                  base_i  <= row_i;
                  addr_ik <= row_i;
                  addr_ij <= row_i;
               end
            end
            if (fin) begin
               beat      <= 1'b0;
               iss_first <= 1'b0;
               iss_last  <= 1'b0;
            end
         end
         if (drain_done) begin
            done <= 1'b1;
            busy <= 1'b0;
         end
         if (spur) err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_syr2k_loop_sequencer.sv
// Bench for syr2k_loop_sequencer: table-driven runs against a loop-nest
// reference model, plus hand sequences for stall, ack overlap and reset.
module tb_syr2k_loop_sequencer;

   localparam int NM = 4;
   localparam int AW = 8;

   typedef struct packed {
      logic [AW-1:0] ik;
      logic [AW-1:0] jk;
      logic [AW-1:0] ij;
      logic          first;
      logic          last;
   } beat_t;

   typedef struct {
      bit s;
      int n;
      bit rnd;
      int dly;
      int eb;
      int el;
      int ee;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic sel = 1'b0;
   logic start = 1'b0;
   logic iss_ready = 1'b0;
   logic wb_ack = 1'b0;
   logic [6:0] n_cfg = '0;

   logic busy_a, done_a, err_a, valid_a, first_a, last_a;
   logic busy_b, done_b, err_b, valid_b, first_b, last_b;
   logic [AW-1:0] ik_a, jk_a, ij_a, ik_b, jk_b, ij_b;
   logic busy, done, err, iss_valid, iss_first, iss_last;
   logic [AW-1:0] ik, jk, ij;
   beat_t cur;

   int total = 0;
   int bad = 0;
   beat_t gotq[$];
   vec_t tv[9];

   always #5 clk = ~clk;

   syr2k_loop_sequencer #(
      .N_MAX(NM), .AW(AW), .DW(7), .LOWER(1'b1), .MAX_OUT(4)
   ) u_lo (
      .clk(clk), .rst(rst), .start(start && !sel), .n_cfg(n_cfg),
      .busy(busy_a), .done(done_a), .err(err_a),
      .iss_valid(valid_a), .iss_ready(iss_ready && !sel),
      .addr_ik(ik_a), .addr_jk(jk_a), .addr_ij(ij_a),
      .iss_first(first_a), .iss_last(last_a), .wb_ack(wb_ack && !sel)
   );

   syr2k_loop_sequencer #(
      .N_MAX(NM), .AW(AW), .DW(7), .LOWER(1'b0), .MAX_OUT(1)
   ) u_full (
      .clk(clk), .rst(rst), .start(start && sel), .n_cfg(n_cfg),
      .busy(busy_b), .done(done_b), .err(err_b),
      .iss_valid(valid_b), .iss_ready(iss_ready && sel),
      .addr_ik(ik_b), .addr_jk(jk_b), .addr_ij(ij_b),
      .iss_first(first_b), .iss_last(last_b), .wb_ack(wb_ack && sel)
   );

   assign busy      = sel ? busy_b  : busy_a;
   assign done      = sel ? done_b  : done_a;
   assign err       = sel ? err_b   : err_a;
   assign iss_valid = sel ? valid_b : valid_a;
   assign iss_first = sel ? first_b : first_a;
   assign iss_last  = sel ? last_b  : last_a;
   assign ik        = sel ? ik_b    : ik_a;
   assign jk        = sel ? jk_b    : jk_a;
   assign ij        = sel ? ij_b    : ij_a;
   assign cur       = {ik, jk, ij, iss_first, iss_last};

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic run(input vec_t v);
      beat_t exq[$];
      beat_t b;
      beat_t hb;
      int    ackq[$];
      int    nb, nl, mout, cyc, maxo, jm;
      bit    held, ok_run, rdy;
      nb = 0; nl = 0; mout = 0; cyc = 0; held = 0;
      maxo = v.s ? 1 : 4;
      ok_run = (v.n > 0) && (v.n <= NM);
      gotq.delete();
      if (ok_run) begin
         for (int ii = 0; ii < v.n; ii++) begin
            jm = v.s ? v.n - 1 : ii;
            for (int jj = 0; jj <= jm; jj++)
               for (int kk = 0; kk < v.n; kk++) begin
                  b.ik = AW'(ii * NM + kk);
                  b.jk = AW'(jj * NM + kk);
                  b.ij = AW'(ii * NM + jj);
                  b.first = (kk == 0);
                  b.last = (kk == v.n - 1);
                  exq.push_back(b);
               end
         end
      end
      sel = v.s; n_cfg = 7'(v.n); start = 1'b1; iss_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", busy, 32'(ok_run));
      chk("err_after_start", err, v.ee);
      chk("done_after_start", done, 32'(!ok_run));
      if (!ok_run) begin
         @(negedge clk);
         chk("done_pulse_short", done, 0);
         chk("no_beat", iss_valid, 0);
         chk("busy_stays_low", busy, 0);
         return;
      end
      while (!done && cyc < 3000) begin
         if (nb < exq.size())
            chk("valid", iss_valid, 32'(!(exq[nb].last && mout == maxo)));
         else
            chk("valid_after_final", iss_valid, 0);
         if (held) chk("hold_while_not_ready", cur, hb);
         rdy = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         iss_ready = rdy;
         wb_ack = 1'b0;
         if (ackq.size() > 0 && ackq[0] <= cyc) begin
            void'(ackq.pop_front());
            wb_ack = 1'b1;
            mout--;
         end
         if (iss_valid && rdy) begin
            gotq.push_back(cur);
            if (nb < exq.size()) chk("beat", cur, exq[nb]);
            else chk("beat_overrun", nb, exq.size() - 1);
            nb++;
            if (cur.last) begin
               nl++;
               ackq.push_back(cyc + v.dly);
               mout++;
            end
         end
         held = iss_valid && !rdy;
         hb = cur;
         start = busy ? 1'($urandom_range(0, 1)) : 1'b0;
         n_cfg = 7'($urandom_range(0, 6));
         @(negedge clk);
         cyc++;
      end
      iss_ready = 1'b0; wb_ack = 1'b0;
      chk("done_seen", done, 1);
      chk("busy_at_done", busy, 0);
      chk("beats", nb, v.eb);
      chk("lasts", nl, v.el);
      chk("acks_pending", ackq.size(), 0);
      chk("err_end", err, v.ee);
      start = 1'b1; n_cfg = 7'd2;
      @(negedge clk);
      start = 1'b0;
      chk("done_one_cycle", done, 0);
      chk("start_with_done_ignored", busy, 0);
   endtask

   initial begin : main
      int xf, cyc, k2;
      bit seen;
      int t2ij[9];
      t2ij = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
      tv[0] = '{0, 3, 0, 2, 18, 6, 0};
      tv[1] = '{1, 3, 0, 2, 27, 9, 0};
      tv[2] = '{0, 3, 1, 2, 18, 6, 0};
      tv[3] = '{0, 0, 0, 2, 0, 0, 0};
      tv[4] = '{0, 5, 0, 2, 0, 0, 1};
      tv[5] = '{0, 1, 1, 1, 1, 1, 0};
      tv[6] = '{0, 4, 1, 20, 40, 10, 0};
      tv[7] = '{1, 4, 1, 3, 64, 16, 0};
      tv[8] = '{1, 2, 0, 10, 8, 4, 0};

      repeat (2) @(negedge clk);
      for (int s = 0; s < 2; s++) begin
         sel = 1'(s);
         #1;
         chk("rst_busy", busy, 0);
         chk("rst_done", done, 0);
         chk("rst_err", err, 0);
         chk("rst_valid", iss_valid, 0);
         chk("rst_beat", cur, 0);
      end
      @(negedge clk);
      rst = 1'b0; sel = 1'b0;
      @(negedge clk);

      wb_ack = 1'b1;
      @(negedge clk);
      wb_ack = 1'b0;
      chk("spurious_ack_err", err, 1);

      for (int r = 0; r < 9; r++) begin
         run(tv[r]);
         if (r == 0) begin
            chk("t1_b14_ik", gotq[14].ik, 10);
            chk("t1_b14_jk", gotq[14].jk, 6);
            chk("t1_b14_ij", gotq[14].ij, 9);
         end
         if (r == 1) begin
            k2 = 0;
            foreach (gotq[x])
               if (gotq[x].last && k2 < 9) begin
                  chk("t2_ij_seq", gotq[x].ij, t2ij[k2]);
                  k2++;
               end
            chk("t2_ij_count", k2, 9);
         end
      end

      // ack lands on the same edge as the second write-back beat
      sel = 1'b0; n_cfg = 7'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0; iss_ready = 1'b1; xf = 0; cyc = 0;
      while (xf < 6 && cyc < 40) begin
         wb_ack = 1'b0;
         if (iss_valid) begin
            xf++;
            if (xf == 4) begin
               chk("sim_last", iss_last, 1);
               wb_ack = 1'b1;
            end
         end
         @(negedge clk);
         cyc++;
      end
      wb_ack = 1'b0; iss_ready = 1'b0;
      chk("sim_transfers", xf, 6);
      repeat (3) @(negedge clk);
      chk("sim_busy_two_out", busy, 1);
      wb_ack = 1'b1;
      @(negedge clk);
      wb_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk("sim_busy_one_out", busy, 1);
      chk("sim_no_early_done", done, 0);
      wb_ack = 1'b1;
      @(negedge clk);
      wb_ack = 1'b0;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      chk("sim_done", 32'(seen), 1);
      chk("sim_err", err, 0);

      // reset in the middle of a run
      sel = 1'b0; n_cfg = 7'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0; iss_ready = 1'b1; xf = 0; cyc = 0;
      while (xf < 7 && cyc < 40) begin
         if (iss_valid) xf++;
         @(negedge clk);
         cyc++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; iss_ready = 1'b0;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_err", err, 0);
      chk("midrst_valid", iss_valid, 0);
      chk("midrst_beat", cur, 0);
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      chk("midrst_no_done", 32'(seen), 0);
      wb_ack = 1'b1;
      @(negedge clk);
      wb_ack = 1'b0;
      chk("late_ack_err", err, 1);
      run(tv[0]);
      chk("rerun_b14_ij", gotq[14].ij, 9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
